// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and FSM state type for the 7-segment scan controller
package disp_pkg;

    localparam logic [7:0] DIGIT_ZERO = 8'b0000_0011;
    localparam logic [7:0] DARK       = 8'hFF;

    // Entry k drives anode k low, selecting digit k+1.
    localparam logic [3:0][3:0] ANODE_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON,
        OFF
    } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_pwm_slot_timer.sv
// rtl/display_scan_ctrl_pwm_slot_timer.sv - per-slot counter with blanking and PWM on-time strobes
module pwm_slot_timer #(
    parameter int SLOT_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 250,
    parameter int CNT_W        = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic [2:0]       brillo_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             slot_start_o,
    output logic             blank_end_o,
    output logic             on_end_o,
    output logic             slot_end_o
);

    localparam int SEG = (SLOT_CYCLES - BLANK_CYCLES) / 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       br_q, br_d;
    logic [CNT_W-1:0] on_last;

    assign slot_start_o = (cnt_q == '0);
    assign blank_end_o  = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end_o   = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    assign cnt_o        = cnt_q;

    // Full brightness never ends early; the slot end takes the FSM straight to BLANK.
    assign on_last  = CNT_W'(BLANK_CYCLES + SEG * (int'(br_q) + 1) - 1);
    assign on_end_o = (br_q != 3'd7) && (cnt_q == on_last);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        br_d  = br_q;
        if (clear_i || slot_end_o) begin
            cnt_d = '0;
        end
        if (slot_start_o) begin
            br_d = brillo_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            br_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            br_q  <= br_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit common-anode scan controller with blanking, PWM and leading-zero suppression
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 250,
    parameter int CNT_W        = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] brillo,
    input  logic       blank_lz,
    input  logic [7:0] catodo1,
    input  logic [7:0] catodo2,
    input  logic [7:0] catodo3,
    input  logic [7:0] catodo4,
    output logic [3:0] anodo,
    output logic [7:0] catodo,
    output logic [1:0] digito,
    output logic       frame_done
);

    scan_state_e      state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0][7:0]  lat_q;
    logic             latch_en;
    logic [3:0]       sup;
    logic             lit;

    logic [3:0]       anodo_q, anodo_d;
    logic [7:0]       catodo_q, catodo_d;
    logic [1:0]       digito_q, digito_d;
    logic             frame_done_q, frame_done_d;

    logic             tmr_clear;
    logic [CNT_W-1:0] cnt;
    logic             slot_start, blank_end, on_end, slot_end;

    assign tmr_clear = !enable || (state_q == IDLE);

    pwm_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (tmr_clear),
        .brillo_i     (brillo),
        .cnt_o        (cnt),
        .slot_start_o (slot_start),
        .blank_end_o  (blank_end),
        .on_end_o     (on_end),
        .slot_end_o   (slot_end)
    );

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        latch_en = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    digit_d  = 2'd0;
                    latch_en = 1'b1;
                end
                BLANK: begin
                    latch_en = slot_start && (digit_q == 2'd0);
                    if (blank_end) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (slot_end) begin
                        state_d = BLANK;
                        digit_d = digit_q + 2'd1;
                    end else if (on_end) begin
                        state_d = OFF;
                    end
                end
                OFF: begin
                    if (slot_end) begin
                        state_d = BLANK;
                        digit_d = digit_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A digit is blanked only if every more significant digit is blanked too.
    always_comb begin
        sup    = 4'b0000;
        sup[3] = blank_lz && (lat_q[3] == DIGIT_ZERO);
        sup[2] = sup[3] && (lat_q[2] == DIGIT_ZERO);
        sup[1] = sup[2] && (lat_q[1] == DIGIT_ZERO);
    end

    // Gating with enable lets the pins go dark on the same edge the FSM drops to IDLE.
    always_comb begin
        lit          = enable && (state_q == ON) && !sup[digit_q];
        anodo_d      = lit ? ANODE_SEL[digit_q] : 4'b1111;
        catodo_d     = lit ? lat_q[digit_q] : DARK;
        digito_d     = enable ? digit_q : 2'd0;
        frame_done_d = enable && ((state_q == ON) || (state_q == OFF)) &&
                       slot_end && (digit_q == 2'd3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            digit_q      <= 2'd0;
            lat_q        <= {4{DARK}};
            anodo_q      <= 4'b1111;
            catodo_q     <= DARK;
            digito_q     <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            if (latch_en) begin
                lat_q <= {catodo4, catodo3, catodo2, catodo1};
            end
            anodo_q      <= anodo_d;
            catodo_q     <= catodo_d;
            digito_q     <= digito_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anodo      = anodo_q;
    assign catodo     = catodo_q;
    assign digito     = digito_q;
    assign frame_done = frame_done_q;

endmodule
